// File: rtl/aes_final_key_gen.sv
// Iterative AES-128 forward key schedule: one round key per clock, holds the round-10 key.
// Optional `AES_KEYGEN_ROUND_TAP_EN adds round_tap_valid, a per-round intermediate-key strobe.

module subbyte (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [7:0] INV_EXP = 8'hFE;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv  = gf_inv(i_byte);
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
    end
endmodule

module aes_final_key_gen #(
    parameter logic [7:0] RCON_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         key_valid,
    output logic [127:0] key_out,
    output logic [3:0]   round_idx
`ifdef AES_KEYGEN_ROUND_TAP_EN
    ,
    output logic         round_tap_valid
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_state, w_state_next;
    logic [127:0] r_key, w_key_next;
    logic [7:0]   r_rcon, w_rcon_next;
    logic [3:0]   r_round, w_round_next;
    logic         r_busy, w_busy_next;
    logic         r_valid, w_valid_next;

    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [7:0]   w_rcon_xt;

    // RotWord of w3 (the least significant word of the working key).
    assign w_rot = {r_key[23:0], r_key[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            subbyte u_sbox (
                .i_byte(w_rot[gi*8 +: 8]),
                .o_byte(w_sub[gi*8 +: 8])
            );
        end
    endgenerate

    assign w_t       = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0      = r_key[127:96] ^ w_t;
    assign w_n1      = r_key[95:64]  ^ w_n0;
    assign w_n2      = r_key[63:32]  ^ w_n1;
    assign w_n3      = r_key[31:0]   ^ w_n2;
    assign w_rcon_xt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_rcon_next  = r_rcon;
        w_round_next = r_round;
        w_busy_next  = r_busy;
        w_valid_next = r_valid;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_key_next   = key_in;
                    w_rcon_next  = RCON_INIT;
                    w_round_next = 4'd0;
                    w_busy_next  = 1'b1;
                    w_valid_next = 1'b0;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_key_next   = {w_n0, w_n1, w_n2, w_n3};
                w_rcon_next  = w_rcon_xt;
                w_round_next = r_round + 4'd1;
                if (r_round == 4'd9) begin
                    w_busy_next  = 1'b0;
                    w_valid_next = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
                w_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_key   <= 128'h0;
            r_rcon  <= 8'h00;
            r_round <= 4'd0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_key   <= w_key_next;
            r_rcon  <= w_rcon_next;
            r_round <= w_round_next;
            r_busy  <= w_busy_next;
            r_valid <= w_valid_next;
        end
    end

`ifdef AES_KEYGEN_ROUND_TAP_EN
    logic r_tap;

    // Every edge taken in RUN produces a fresh round key (rounds 1..10).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_tap <= 1'b0;
        else        r_tap <= (r_state == RUN);
    end

    assign round_tap_valid = r_tap;
`endif

    assign busy      = r_busy;
    assign key_valid = r_valid;
    assign key_out   = r_key;
    assign round_idx = r_round;
endmodule

// File: tb/tb_aes_final_key_gen.sv
// Randomized self-checking bench for aes_final_key_gen against a word-array key expansion model.
// Build with +define+AES_KEYGEN_ROUND_TAP_EN to also check round_tap_valid.

module tb_aes_final_key_gen;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         key_valid;
    logic [127:0] key_out;
    logic [3:0]   round_idx;
`ifdef AES_KEYGEN_ROUND_TAP_EN
    logic         round_tap_valid;
`endif

    aes_final_key_gen dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .key_valid(key_valid),
        .key_out  (key_out),
        .round_idx(round_idx)
`ifdef AES_KEYGEN_ROUND_TAP_EN
        ,
        .round_tap_valid(round_tap_valid)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv [256];
        logic [7:0] c;
        logic [7:0] b;
        logic [7:0] s;
        c = 8'h63;
        inv[0] = 8'h00;
        for (int x = 1; x < 256; x++)
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv[x] = 8'(y);
        for (int x = 0; x < 256; x++) begin
            b = inv[x];
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    logic [127:0] m_rk [11];
    bit           m_busy = 0, m_valid = 0, m_loaded = 0, m_tap = 0;
    int           m_round = 0;

    function automatic void expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                for (int b = 0; b < 4; b++) t[8*b +: 8] = sbox_tab[t[8*b +: 8]];
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_valid = 0; m_loaded = 0; m_tap = 0; m_round = 0;
        end else begin
            m_tap = m_busy;
            if (!m_busy && start) begin
                expand(key_in);
                m_loaded = 1; m_round = 0; m_busy = 1; m_valid = 0;
            end else if (m_busy) begin
                m_round++;
                if (m_round == 10) begin
                    m_busy = 0; m_valid = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", 128'(busy), 128'(m_busy));
        chk("key_valid", 128'(key_valid), 128'(m_valid));
        chk("round_idx", 128'(round_idx), 128'(m_round));
        chk("key_out", key_out, m_loaded ? m_rk[m_round] : 128'h0);
        chk("busy_valid_excl", 128'(busy & key_valid), 128'h0);
`ifdef AES_KEYGEN_ROUND_TAP_EN
        chk("round_tap_valid", 128'(round_tap_valid), 128'(m_tap));
`endif
    end

    // ---------------- directed + random stimulus ----------------
    logic [127:0] cap_r1, cap_r9, cap_tap9;
    int           taps;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic accept(input logic [127:0] key);
        @(negedge clk);
        start = 1'b1;
        key_in = key;
        @(negedge clk);
        start = 1'b0;
        key_in = rand128();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        taps = 0;
        cap_r1 = '0; cap_r9 = '0; cap_tap9 = '0;
        while (!key_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (round_idx == 4'd1) cap_r1 = key_out;
            if (round_idx == 4'd9) cap_r9 = key_out;
`ifdef AES_KEYGEN_ROUND_TAP_EN
            if (round_tap_valid) begin
                taps++;
                if (taps == 9) cap_tap9 = key_out;
            end
`endif
        end
        chk("done_within_bound", 128'(key_valid), 128'h1);
    endtask

    task automatic step_to_round(input logic [3:0] r);
        int n;
        n = 0;
        while (round_idx != r && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round", 128'(round_idx), 128'(r));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int pulses;
        int last;
        build_sbox();

        repeat (2) @(negedge clk);
        chk("reset_busy", 128'(busy), 128'h0);
        chk("reset_valid", 128'(key_valid), 128'h0);
        chk("reset_key", key_out, 128'h0);
        chk("reset_round", 128'(round_idx), 128'h0);
        #2 reset = 1'b1;

        // FIPS-197 vector
        accept(FIPS_KEY);
        chk("e0_busy", 128'(busy), 128'h1);
        chk("e0_round", 128'(round_idx), 128'h0);
        wait_done(cyc);
        chk("fips_latency", 128'(cyc), 128'd10);
        chk("fips_r1", cap_r1, FIPS_R1);
        chk("fips_r9", cap_r9, FIPS_R9);
        chk("fips_r10", key_out, FIPS_R10);
        chk("fips_round10", 128'(round_idx), 128'd10);
        chk("fips_busy_low", 128'(busy), 128'h0);
`ifdef AES_KEYGEN_ROUND_TAP_EN
        chk("tap_count", 128'(taps), 128'd10);
        chk("tap9_key", cap_tap9, FIPS_R9);
`endif
        $display("txn fips: latency=%0d key_out=%h", cyc, key_out);
        repeat (3) @(negedge clk);
        chk("done_hold_key", key_out, FIPS_R10);
        chk("done_hold_valid", 128'(key_valid), 128'h1);

        // All-zero key
        accept(128'h0);
        wait_done(cyc);
        chk("zero_latency", 128'(cyc), 128'd10);
        chk("zero_r10", key_out, ZERO_R10);
        $display("txn zero: latency=%0d key_out=%h", cyc, key_out);

        // start during RUN is ignored
        accept(FIPS_KEY);
        step_to_round(4'd4);
        start = 1'b1;
        key_in = rand128();
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("ignore_start_r10", key_out, FIPS_R10);
        $display("txn ignore_start: key_out=%h", key_out);

        // reset mid-RUN
        accept(rand128());
        step_to_round(4'd6);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", 128'(busy), 128'h0);
        chk("midrst_valid", 128'(key_valid), 128'h0);
        chk("midrst_key", key_out, 128'h0);
        chk("midrst_round", 128'(round_idx), 128'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        accept(FIPS_KEY);
        wait_done(cyc);
        chk("after_rst_r10", key_out, FIPS_R10);
        $display("txn reset_recover: key_out=%h", key_out);

        // start held high
        @(negedge clk);
        start = 1'b1;
        key_in = FIPS_KEY;
        pulses = 0;
        last = -1;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                chk("held_key", key_out, FIPS_R10);
                if (last >= 0) chk("held_spacing", 128'(i - last), 128'd11);
                last = i;
            end
        end
        start = 1'b0;
        chk("held_pulses", 128'(pulses), 128'd3);
        $display("txn held_start: pulses=%0d", pulses);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            key_in = rand128();
            if (key_valid) $display("txn random: cycle=%0d key_out=%h", i, key_out);
            if ($urandom_range(0, 150) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end
        start = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_final_key_gen.md
# aes_final_key_gen

Iterative forward AES-128 key schedule. It takes the 128-bit cipher key and produces the round-10 key. It sits directly upstream of the inverse key expansion stage: its `key_out`/`key_valid` drive that stage's key input and enable. It computes one full round key per clock using four `subbyte` instances, and holds the result until the next start.

## Interface
- `RCON_INIT`, 8'h01, round constant loaded at start; must stay 8'h01 for AES-128 compliance.
- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-low reset; clears all state when low.
- `start`  in  1  request pulse; sampled on rising `clk`; accepted only in IDLE or DONE.
- `key_in`  in  128  cipher key, word 0 in [127:96]; captured on the accepting edge only.
- `busy`  out  1  high while rounds are being computed.
- `key_valid`  out  1  high in DONE; `key_out` is the round-10 key while high.
- `key_out`  out  128  working key register, word 0 in [127:96].
- `round_idx`  out  4  index of the round key currently held in `key_out` (0..10).

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, `reset`=0):
  - state=IDLE, `busy`=0, `key_valid`=0, `key_out`=0, `round_idx`=0, rcon=8'h00.
- IDLE, `start`=1:
  - `key_out`<=`key_in`, rcon<=`RCON_INIT`, `round_idx`<=0.
  - `busy`<=1, go to RUN.
- RUN, each edge, with w0..w3 = `key_out` words:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - `key_out`<={n0,n1,n2,n3}, `round_idx`<=`round_idx`+1.
  - rcon<=xtime(rcon), i.e. {rcon[6:0],0}, xor 8'h1b if rcon[7]=1.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- RUN, `round_idx`=9 at the edge (computing round 10):
  - go to DONE, `busy`<=0, `key_valid`<=1.
- DONE:
  - `key_out`, `round_idx`=10 and `key_valid`=1 hold indefinitely.
- DONE, `start`=1: behaves exactly as from IDLE.
  - `key_valid`<=0 on that same edge; the new key is captured.
- `start` in RUN: ignored, no restart, no queueing; `key_in` not sampled.
- `start` held high continuously:
  - accepted at the first eligible edge;
  - again at the first edge in DONE, so `key_valid` is high for exactly one cycle per pass.
- Reset asserted mid-RUN: immediate return to IDLE with reset values; no partial result is flagged valid.

## Timing
- Accepting edge E0: `busy`=1, `round_idx`=0.
- Edge Ek (k=1..10): `key_out` = round-k key, `round_idx`=k.
- After E10: `key_valid`=1, `busy`=0.
- Latency: 10 cycles from the accepting edge to `key_valid`. Restart-to-restart minimum is 11 cycles.
- `busy` and `key_valid` are never high together; both are registered outputs.
- Downstream stage samples on falling `clk`; `key_out` is stable a half cycle before that sample.

## Configuration
- `AES_KEYGEN_ROUND_TAP_EN` defined:
  - adds output `round_tap_valid` (1 bit, registered, reset 0);
  - it pulses high for one cycle after each edge E1..E10, marking `key_out` as a valid intermediate round key for forward-cipher consumers.
- Not defined: port absent; no other behaviour changes.

## Test plan
- FIPS-197 vector: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `start` pulse.
  - After E1, `key_out`=a0fafe1788542cb123a339392a6c7605.
  - After E10, `key_out`=d014f9a8c9ee2589e13f0cc8b6630ca6, `key_valid`=1, `round_idx`=10.
- All-zero key -> round-10 key b4ef5bcb3e92e21123e951cf6f8f188e, valid exactly 10 cycles after the accepting edge.
- `start` pulse at `round_idx`=4 with a different `key_in` -> ignored; the final result still matches the first key.
- `reset` low at `round_idx`=6 -> outputs 0 / IDLE immediately; next start with the FIPS key gives the correct result.
- `start` held high with the FIPS key -> `key_valid` one-cycle pulses every 11 cycles, same result each time.
- With `AES_KEYGEN_ROUND_TAP_EN`: exactly 10 `round_tap_valid` pulses per pass; the 9th coincides with `key_out`=ac7766f319fadc2128d12941575c006e.
